gesture_uart_reporter: RTL and testbench
========================================

Name: gesture_uart_reporter

Overview:
Downstream consumer of the persistence-filter stage. It captures each confirmed gesture event (gesture, gesture_valid, gesture_confidence) into a small FIFO. Each event is serialized as a 3-byte packet over an 8N1 UART TX line to the host. This decouples single-cycle gesture pulses from the slow serial link and counts events lost to overflow.

Parameters:
CLK_FREQ_HZ, 12000000, system clock frequency
BAUD_RATE, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer divide, must be >= 4)
FIFO_DEPTH, 4, event FIFO entries (power of two, >= 2)

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
gesture  input  2  confirmed gesture code
gesture_valid  input  1  single-cycle event strobe
gesture_confidence  input  4  confidence 0..15
uart_tx  output  1  serial line, idle high
tx_busy  output  1  high while a packet is in flight or the FIFO is non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow_count  output  8  dropped-event counter, saturates at 255

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0: uart_tx=1, tx_busy=0, fifo_count=0, overflow_count=0, FIFO emptied, FSM=IDLE, baud/bit/byte counters=0. Reset mid-frame aborts the frame; the line returns high immediately with no partial-byte completion.
- FIFO entry: 6 bits {confidence[3:0], gesture[1:0]}, written on the clk edge ending the cycle in which gesture_valid=1.
- Push acceptance: push accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
- Overflow: otherwise the new event is dropped (oldest data kept) and overflow_count increments, saturating at 255.
- Simultaneous push and pop: count is unchanged.
- Packet format, in order, each byte LSB first:
  - B0 = 0xA5 (sync)
  - B1 = {confidence[3:0], 2'b00, gesture[1:0]}
  - B2 = B0 ^ B1
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into a packet latch, byte_idx=0, go to START. The latch must hold the packet so later pushes cannot corrupt it.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: shift out 8 bits, each held CLKS_PER_BIT cycles, then STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. Then, if byte_idx<2, increment byte_idx and go to START. Else go to IDLE.
- Latency: from an idle, empty state, a gesture_valid in cycle N gives FIFO write at edge N+1 and pop at edge N+2. The uart_tx falling edge (start bit) is registered and appears after edge N+2.
- Packet length: 30*CLKS_PER_BIT cycles. Back-to-back packets have no gap beyond the stop bit plus one IDLE cycle.
- uart_tx is driven directly from a flop (glitch-free).
- tx_busy = (state != IDLE) || (fifo_count != 0), registered.
- gesture_valid with X on gesture/confidence is never sampled when gesture_valid=0.

Decomposition:
- gesture_pkg holds:
  - gesture code typedef (2-bit enum)
  - UART_SYNC_BYTE = 8'hA5
  - PKT_BYTES = 3
  - packet byte typedef
- Sub-module uart_tx_byte owns the baud counter, START/DATA/STOP sequencing and the shift register.
  - Interface: clk, rst_n, data[7:0], start, busy, done, tx.
- The top holds the FIFO, the overflow counter and packet/byte sequencing.

Test Plan:
1. CLK_FREQ_HZ=1000000, BAUD_RATE=100000 (10 clks/bit); single event gesture=2, confidence=9 -> decoded bytes 0xA5, 0x92, 0x37. The start bit appears two edges after the strobe and each bit lasts exactly 10 cycles.
2. gesture_valid high for 6 consecutive cycles (gesture 0..3, 0, 1) while idle -> 5 packets transmitted in order, 6th event dropped, overflow_count=1, fifo_count peaks at 4.
3. Push while full in the same cycle the FSM pops -> event accepted, overflow_count unchanged, all packets delivered.
4. rst_n asserted low mid-DATA of B1 -> uart_tx=1 within the same cycle (asynchronous). After release: fifo_count=0, no residual bits, and a new event transmits cleanly.
5. 300 events with a permanently busy link (strobes every cycle) -> overflow_count saturates at 255, with no wrap to 0.
6. Two events 1 cycle apart after idle -> second packet's start bit begins exactly 1 cycle after the first packet's final stop bit ends; tx_busy stays high across the gap and drops 1 cycle after the last stop bit.

Source files
------------

// File: rtl/gesture_pkg.sv
// rtl/gesture_pkg.sv - shared types, constants and packet byte builder for the gesture UART reporter
package gesture_pkg;

  typedef enum logic [1:0] {
    GEST_0 = 2'd0,
    GEST_1 = 2'd1,
    GEST_2 = 2'd2,
    GEST_3 = 2'd3
  } gesture_e;

  typedef logic [7:0] pkt_byte_t;

  localparam pkt_byte_t UART_SYNC_BYTE = 8'hA5;
  localparam int        PKT_BYTES      = 3;

  typedef struct packed {
    logic [3:0] confidence;
    gesture_e   gesture;
  } gesture_event_t;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // Byte idx of the 3-byte packet: sync, payload, then sync^payload as a check byte.
  function automatic pkt_byte_t pkt_byte(input gesture_event_t ev, input logic [1:0] idx);
    pkt_byte_t b1;
    b1 = {ev.confidence, 2'b00, ev.gesture};
    case (idx)
      2'd0:    pkt_byte = UART_SYNC_BYTE;
      2'd1:    pkt_byte = b1;
      default: pkt_byte = UART_SYNC_BYTE ^ b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer; a start on the final stop cycle chains the next byte with no gap
module uart_tx_byte
  import gesture_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  tx_state_e     state, state_n;
  logic [CW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, sh_n;
  logic          tx_n;
  logic          bit_end;

  assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign busy    = (state != TX_IDLE);
  assign done    = (state == TX_STOP) && bit_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shreg    <= sh_n;
      tx       <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = bit_end ? '0 : baud_cnt + 1'b1;
    bit_n   = bit_idx;
    sh_n    = shreg;
    tx_n    = tx;
    case (state)
      TX_IDLE: begin
        baud_n = '0;
        if (start) begin
          state_n = TX_START;
          sh_n    = data;
          tx_n    = 1'b0;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_n = TX_DATA;
          bit_n   = '0;
          tx_n    = shreg[0];
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_n = TX_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_idx + 1'b1;
            sh_n  = shreg >> 1;
            tx_n  = shreg[1];
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (start) begin
            state_n = TX_START;
            sh_n    = data;
            tx_n    = 1'b0;
          end else begin
            state_n = TX_IDLE;
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/gesture_uart_reporter.sv
// rtl/gesture_uart_reporter.sv - buffers gesture events in a FIFO and reports each as a 3-byte UART packet
module gesture_uart_reporter
  import gesture_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  gesture,
  input  logic                        gesture_valid,
  input  logic [3:0]                  gesture_confidence,
  output logic                        uart_tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  overflow_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int AW           = $clog2(FIFO_DEPTH);

  typedef enum logic {PKT_IDLE, PKT_SEND} pkt_state_e;

  gesture_event_t mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  gesture_event_t pkt_ev;
  pkt_state_e     pkt_state, pkt_state_n;
  logic [1:0]     byte_idx, byte_idx_n;
  logic           pop, push;
  logic           tx_start, tx_done, byte_busy;
  pkt_byte_t      tx_data;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the event.
  assign pop        = (pkt_state == PKT_IDLE) && (count != '0);
  assign push       = gesture_valid && ((count < (AW+1)'(FIFO_DEPTH)) || pop);
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= gesture_event_t'({gesture_confidence, gesture});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      overflow_count <= '0;
      pkt_ev         <= '0;
      tx_busy        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        pkt_ev <= mem[rd_ptr];
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (gesture_valid && !push && (overflow_count != 8'hFF))
        overflow_count <= overflow_count + 1'b1;
      tx_busy <= byte_busy || (pkt_state != PKT_IDLE) || (count != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_state <= PKT_IDLE;
      byte_idx  <= '0;
    end else begin
      pkt_state <= pkt_state_n;
      byte_idx  <= byte_idx_n;
    end
  end

  // The byte serializer is started combinationally so the start bit lands on the pop edge.
  always_comb begin
    pkt_state_n = pkt_state;
    byte_idx_n  = byte_idx;
    tx_start    = 1'b0;
    tx_data     = UART_SYNC_BYTE;
    case (pkt_state)
      PKT_IDLE: begin
        if (pop) begin
          pkt_state_n = PKT_SEND;
          byte_idx_n  = '0;
          tx_start    = 1'b1;
        end
      end
      PKT_SEND: begin
        if (tx_done) begin
          if (byte_idx < 2'(PKT_BYTES - 1)) begin
            byte_idx_n = byte_idx + 1'b1;
            tx_start   = 1'b1;
            tx_data    = pkt_byte(pkt_ev, byte_idx + 1'b1);
          end else begin
            pkt_state_n = PKT_IDLE;
          end
        end
      end
      default: pkt_state_n = PKT_IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .data (tx_data),
    .start(tx_start),
    .busy (byte_busy),
    .done (tx_done),
    .tx   (uart_tx)
  );

endmodule

// File: tb/tb_gesture_uart_reporter.sv
// tb/tb_gesture_uart_reporter.sv - randomized self-checking bench with a per-cycle behavioural line model
module tb_gesture_uart_reporter;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DEPTH  = 4;
  localparam int C      = CLK_HZ / BAUD;
  localparam int FRAME  = 30 * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] gesture = '0;
  logic       gesture_valid = 1'b0;
  logic [3:0] gesture_confidence = '0;
  logic       uart_tx, tx_busy;
  logic [2:0] fifo_count;
  logic [7:0] overflow_count;

  int checks = 0;
  int errors = 0;
  int peak = 0;
  int m_pkts = 0;

  always #5 clk = ~clk;

  gesture_uart_reporter #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .gesture           (gesture),
    .gesture_valid     (gesture_valid),
    .gesture_confidence(gesture_confidence),
    .uart_tx           (uart_tx),
    .tx_busy           (tx_busy),
    .fifo_count        (fifo_count),
    .overflow_count    (overflow_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of pending events, the packet on the wire and its cycle position.
  logic [5:0] m_q[$];
  int         m_ovf = 0;
  int         m_pos = -1;
  logic [5:0] m_pkt = '0;
  logic       m_busy = 1'b0;
  logic       m_pop;

  function automatic logic [7:0] m_byte(input logic [5:0] ev, input int i);
    logic [7:0] b1;
    b1 = {ev[5:2], 2'b00, ev[1:0]};
    if (i == 0) return 8'hA5;
    if (i == 1) return b1;
    return 8'hA5 ^ b1;
  endfunction

  function automatic logic m_line();
    int w;
    logic [7:0] b;
    if (m_pos < 0) return 1'b1;
    w = (m_pos % (10 * C)) / C;
    b = m_byte(m_pkt, m_pos / (10 * C));
    if (w == 0) return 1'b0;
    if (w == 9) return 1'b1;
    return b[w-1];
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_ovf  = 0;
      m_pos  = -1;
      m_busy = 1'b0;
    end else begin
      m_pop  = (m_pos < 0) && (m_q.size() > 0);
      m_busy = (m_pos >= 0) || (m_q.size() != 0);
      if (m_pos >= 0) m_pos = (m_pos == FRAME - 1) ? -1 : m_pos + 1;
      if (m_pop) begin
        m_pkt = m_q.pop_front();
        m_pos = 0;
        m_pkts++;
      end
      if (gesture_valid) begin
        if (m_q.size() < DEPTH) m_q.push_back({gesture_confidence, gesture});
        else if (m_ovf < 255) m_ovf++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("uart_tx", uart_tx, m_line());
      check("fifo_count", fifo_count, m_q.size());
      check("overflow_count", overflow_count, m_ovf);
      check("tx_busy", tx_busy, m_busy);
      if (int'(fifo_count) > peak) peak = fifo_count;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic strobe(input logic [1:0] g, input logic [3:0] c);
    gesture            = g;
    gesture_confidence = c;
    gesture_valid      = 1'b1;
    @(negedge clk);
    gesture_valid      = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((m_pos >= 0 || m_q.size() != 0 || tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", n < budget, 1);
    repeat (3) @(negedge clk);
  endtask

  logic       line [0:2*FRAME+2];
  logic       busy [0:2*FRAME+2];
  logic [7:0] exp1 [3];
  logic [7:0] b;
  logic       quiet;
  int         n, pk0;

  initial begin
    exp1 = '{8'hA5, 8'h92, 8'h37};
    repeat (3) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow_count, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single event: timing of the start bit and decoded bytes.
    strobe(2'd2, 4'd9);
    check("t1_line_before_start", uart_tx, 1);
    for (int k = 0; k < FRAME + 2; k++) begin
      @(negedge clk);
      line[k] = uart_tx;
    end
    check("t1_start_first", line[0], 0);
    check("t1_start_last", line[C-1], 0);
    check("t1_bit0_begin", line[C], 1);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 8; j++) b[j] = line[(i*10 + 1 + j)*C + C/2];
      check($sformatf("t1_byte%0d", i), b, exp1[i]);
      check($sformatf("t1_stop%0d", i), line[(i*10 + 9)*C + C/2], 1);
    end
    check("t1_idle_after", line[FRAME], 1);
    wait_drain(500);

    // Six back-to-back strobes: one dropped.
    peak = 0;
    pk0  = m_pkts;
    for (int i = 0; i < 6; i++) strobe(2'(i % 4), 4'($urandom_range(0, 15)));
    wait_drain(2500);
    check("t2_overflow", overflow_count, 1);
    check("t2_peak", peak, 4);
    check("t2_packets", m_pkts - pk0, 5);

    // Push into a full FIFO on the pop cycle.
    for (int i = 0; i < 5; i++) strobe(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    n = 0;
    while (!(m_pos < 0 && m_q.size() == DEPTH) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("t3_reach_pop", n < 600, 1);
    strobe(2'd2, 4'hF);
    check("t3_full_kept", fifo_count, 4);
    check("t3_no_drop", overflow_count, 1);
    wait_drain(2500);
    check("t3_overflow_end", overflow_count, 1);

    // Asynchronous reset in the middle of a 0 data bit of B1.
    strobe(2'd1, 4'hC);
    strobe(2'd3, 4'h5);
    n = 0;
    while (m_pos != 13*C + C/2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t4_reach", n < 400, 1);
    @(posedge clk);
    #2;
    check("t4_bit_low", uart_tx, 0);
    rst_n = 1'b0;
    #1;
    check("t4_async_tx", uart_tx, 1);
    check("t4_async_busy", tx_busy, 0);
    check("t4_async_fifo", fifo_count, 0);
    check("t4_async_ovf", overflow_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      quiet = quiet & uart_tx & ~tx_busy;
    end
    check("t4_quiet", quiet, 1);
    strobe(2'd0, 4'h7);
    wait_drain(500);

    // Saturating overflow counter.
    for (int i = 0; i < 300; i++) strobe(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    check("t5_saturated", overflow_count, 255);
    wait_drain(2500);
    check("t5_still_saturated", overflow_count, 255);

    // Two events one cycle apart: inter-packet gap and tx_busy tail.
    strobe(2'd1, 4'd3);
    strobe(2'd2, 4'd6);
    line[0] = uart_tx;
    busy[0] = tx_busy;
    for (int k = 1; k <= 2*FRAME + 2; k++) begin
      @(negedge clk);
      line[k] = uart_tx;
      busy[k] = tx_busy;
    end
    check("t6_first_start", line[0], 0);
    check("t6_last_stop", line[FRAME-1], 1);
    check("t6_gap_line", line[FRAME], 1);
    check("t6_gap_busy", busy[FRAME], 1);
    check("t6_second_start", line[FRAME+1], 0);
    check("t6_busy_tail", busy[2*FRAME+1], 1);
    check("t6_busy_drop", busy[2*FRAME+2], 0);
    wait_drain(500);

    // Sparse random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) strobe(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      else @(negedge clk);
    end
    wait_drain(8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
